// File: rtl/register_file_mp_pkg.sv
// Shared types and width defaults for the multi-port register file.
package regfile_pkg;

   typedef enum logic {
      SWEEP = 1'b0,
      READY = 1'b1
   } rf_state_t;

   localparam int RF_DATA_W = 8;
   localparam int RF_ADDR_W = 3;

   // Number of registers addressed by an addr_w-bit address.
   function automatic int rf_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write port, packed read ports, clear/status.
interface register_file_mp_if #(
   parameter int DATA_W = regfile_pkg::RF_DATA_W,
   parameter int ADDR_W = regfile_pkg::RF_ADDR_W,
   parameter int N_READ = 2
);
   localparam int DEPTH = regfile_pkg::rf_depth(ADDR_W);

   logic                       enable_write;
   logic [ADDR_W-1:0]          write_to;
   logic [DATA_W-1:0]          data_in;
   logic [N_READ*ADDR_W-1:0]   read_from;
   logic [N_READ*DATA_W-1:0]   data_out;
   logic                       clear_req;
   logic                       ready;
   logic [DEPTH-1:0]           written_mask;

   modport master (
      output enable_write, write_to, data_in, read_from, clear_req,
      input  data_out, ready, written_mask
   );

   modport slave (
      input  enable_write, write_to, data_in, read_from, clear_req,
      output data_out, ready, written_mask
   );

endinterface

// File: rtl/register_file_mp_sweep_ctrl.sv
// Clear-sweep controller: walks a counter over every register after reset
// or on request, then holds READY until the next clear request.
module regfile_sweep_ctrl
   import regfile_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_req,
   output logic              ready,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(rf_depth(ADDR_W) - 1);

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // Next state: sweep one register per cycle, leave after the last one;
   // in READY a clear request restarts the walk from register 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         SWEEP: begin
            if (cnt_q == LAST) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         READY: begin
            if (clear_req) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = SWEEP;
            cnt_d   = '0;
         end
      endcase
   end

   // State and counter registers; reset always restarts the sweep.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= SWEEP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready      = (state_q == READY);
   assign sweep_we   = (state_q == SWEEP);
   assign sweep_addr = cnt_q;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read register file with optional hardwired zero
// register, write-to-read bypass, clear sweep and written-register mask.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int N_READ   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic               clk,
   input logic               reset_n,
   register_file_mp_if.slave bus
);

   localparam int DEPTH = rf_depth(ADDR_W);

   logic              ready;
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              wr_ok;
   logic              wr_zero;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  mask_q, mask_d;

   regfile_sweep_ctrl #(.ADDR_W(ADDR_W)) u_sweep (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear_req  (bus.clear_req),
      .ready      (ready),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   assign wr_zero = ZERO_REG && (bus.write_to == '0);
   assign wr_ok   = ready && bus.enable_write && !wr_zero;

   // Array update: the sweep owns the array while active, otherwise the
   // user write port. A write coinciding with a clear request still lands;
   // the sweep that follows overwrites it.
   always_comb begin
      mem_d = mem_q;
      if (sweep_we) begin
         mem_d[sweep_addr] = '0;
      end else if (wr_ok) begin
         mem_d[bus.write_to] = bus.data_in;
      end
   end

   // Array storage has no reset; the sweep is what clears it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Written mask: mark accepted writes, wipe on entry to a clear sweep.
   always_comb begin
      mask_d = mask_q;
      if (wr_ok) begin
         mask_d[bus.write_to] = 1'b1;
      end
      if (ready && bus.clear_req) begin
         mask_d = '0;
      end
   end

   // Mask register, cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end

   // Combinational read ports: forced zero while not ready or on the zero
   // register, optionally forwarding the in-flight write data.
   for (genvar k = 0; k < N_READ; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rdata;

      assign addr = bus.read_from[k*ADDR_W +: ADDR_W];

      always_comb begin
         rdata = mem_q[addr];
         if (!ready) begin
            rdata = '0;
         end else if (ZERO_REG && (addr == '0)) begin
            rdata = '0;
         end else if (BYPASS && bus.enable_write && (addr == bus.write_to)) begin
            rdata = bus.data_in;
         end
      end

      assign bus.data_out[k*DATA_W +: DATA_W] = rdata;
   end

   assign bus.ready        = ready;
   assign bus.written_mask = mask_q;

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the 8x8 two-read register file used by the picoMIPS datapath.
- Width, depth and read-port count are generalised.
- Adds optional hardwired-zero register 0 and same-cycle write-to-read bypass.
- A sequential clear-sweep FSM zeroes the array after reset or on request, with a ready indicator; a per-register written mask supports debug and scoreboard use.

Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- N_READ, 2, number of independent asynchronous read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = read of the register being written this cycle returns data_in

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- enable_write  in  1  write strobe
- write_to  in  ADDR_W  write address
- data_in  in  DATA_W  write data
- read_from  in  N_READ*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- data_out  out  N_READ*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- clear_req  in  1  request a full clear sweep; sampled only in READY
- ready  out  1  1 = array valid, writes accepted
- written_mask  out  DEPTH  bit i set when register i has been written since the last sweep

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - FSM goes to SWEEP and the sweep counter is set to 0.
  - ready=0 and written_mask=0 from the next edge.
  - Array contents are not reset directly; the sweep clears them.
- FSM states SWEEP and READY:
  - SWEEP: each cycle writes 0 to reg[cnt], then cnt++. At cnt=DEPTH-1 the last register is written and the FSM enters READY on the next edge. A sweep takes exactly DEPTH cycles after reset release.
  - READY: ready=1. clear_req=1 at an edge moves to SWEEP with cnt=0 and written_mask cleared. A write in that same cycle is still performed, then overwritten by the sweep.
- Reset mid-sweep restarts the sweep at cnt=0.
- Writes, in READY only:
  - enable_write=1 stores data_in into reg[write_to] at the edge and sets written_mask[write_to].
  - With ZERO_REG=1 and write_to=0, the write is dropped and mask bit 0 is never set.
  - During SWEEP, enable_write is ignored (no error flag).
- Reads (combinational, zero latency):
  - data_out[k] = reg[read_from[k]].
  - With ZERO_REG=1 and address 0, the port returns 0.
  - While ready=0, all ports return 0 regardless of array contents.
  - Bypass (BYPASS=1 and ready=1 and enable_write=1 and read_from[k]==write_to, excluding zero reg): data_out[k]=data_in in the same cycle.
  - BYPASS=0: reads show the old value until after the edge.
- Several ports may read the same address simultaneously; all return identical data.
- No arithmetic beyond cnt increment. cnt is ADDR_W bits wide and wraps to 0 only on re-entry to SWEEP.

Decomposition:
- Package regfile_pkg:
  - typedef rf_state_t {SWEEP, READY}
  - default width constants RF_DATA_W=8, RF_ADDR_W=3
  - helper function rf_depth(addr_w)
- One natural sub-module, regfile_sweep_ctrl: owns the FSM, cnt, ready, and the sweep write enable/address mux.
- The top level holds the array, read muxes, bypass and written_mask.

Test Plan:
- Release reset_n after 2 cycles; count cycles until ready=1 → ready rises exactly 8 cycles after release; all data_out=00 and written_mask=00 throughout.
- In READY, write A5 to r3 and 3C to r5, then read r3/r5 → data_out = A5/3C; written_mask = 0x28.
- Write 7E to r0 with ZERO_REG=1 and read r0 on both ports → 00; mask bit 0 stays 0.
- Write 5A to r6 while read_from0=6 in the same cycle → BYPASS=1: data_out0=5A combinationally. BYPASS=0: old value 00, then 5A after the edge.
- Write r2=11, then pulse clear_req → ready=0 for 8 cycles; writes of FF during the sweep are ignored; afterwards r2 reads 00 and written_mask=00.
- Assert reset_n=0 at sweep cycle 4 → the sweep restarts; ready rises 8 cycles after release, not 4. Instantiate N_READ=4, DATA_W=16, ADDR_W=4: write BEEF to r15 and read it on all four ports → BEEF on each.
